// File: rtl/aes_pkg.sv
// Shared definitions for the AES block loader.
//   AES_BLOCK_W          width of one plaintext block / key
//   AES_WORD_W           width of one streamed input word
//   AES_WORDS_PER_BLOCK  words needed to fill a block
//   AES_CNT_W            width of a per-group word counter
//   state_t              loader FSM states
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;
  localparam int AES_CNT_W           = $clog2(AES_WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/aes_word_assembler.sv
// Shift-in assembler: collects AES_WORDS_PER_BLOCK words into one block.
// The first word of a group ends up in the top word slot, the last in the
// bottom slot.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear of the word counter and the full flag
//   wr_i     accept word_i this cycle
//   word_i   incoming word
//   block_o  assembled block (always the register contents)
//   full_o   a complete group has been assembled
//
// full_o is recomputed on every write: it is set by the last word of a
// group and dropped by the first word of the next group. A block that is
// kept full by its user (no writes) therefore stays full until clr_i.
module aes_word_assembler
  import aes_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  logic [AES_WORD_W-1:0]  word_i,
  output logic [AES_BLOCK_W-1:0] block_o,
  output logic                   full_o
);

  logic [AES_BLOCK_W-1:0] block_q, block_d;
  logic [AES_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   full_q, full_d;

  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    if (clr_i) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (wr_i) begin
      block_d = {block_q[AES_BLOCK_W-AES_WORD_W-1:0], word_i};
      // Counter wraps naturally after the last word of a group.
      cnt_d   = cnt_q + AES_CNT_W'(1);
      full_d  = (cnt_q == AES_CNT_W'(AES_WORDS_PER_BLOCK - 1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      block_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      block_q <= block_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign block_o = block_q;
  assign full_o  = full_q;

endmodule

// File: rtl/aes_block_loader.sv
// Upstream feeder for AES_top. Assembles a 128-bit plaintext block and a
// 128-bit key from a 32-bit word stream, launches one encryption, waits for
// completion (or times out), then enforces an idle gap before the next one.
//   AES_clk / AES_rst_n      clock, asynchronous active-low reset
//   in_word/in_valid/in_ready/in_is_key  word stream (see handshake below)
//   err_clr                  clears timeout_err (a coincident timeout wins)
//   AES_data_out_valid       completion from AES_top
//   AES_en/AES_data_in/AES_key_in  launch interface to AES_top
//   busy                     block in flight (RUN or GAP)
//   timeout_err              sticky completion-timeout flag
//   blocks_launched          wrapping launch counter
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on state, the assembler flags and in_is_key (which
// selects the destination group); it never depends on in_valid.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst_n,
  input  logic [AES_WORD_W-1:0]  in_word,
  input  logic                   in_valid,
  input  logic                   in_is_key,
  output logic                   in_ready,
  input  logic                   err_clr,
  input  logic                   AES_data_out_valid,
  output logic                   AES_en,
  output logic [AES_BLOCK_W-1:0] AES_data_in,
  output logic [AES_BLOCK_W-1:0] AES_key_in,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       blocks_launched
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   blk_q, blk_d;
  logic               err_q, err_d;

  logic data_full, key_valid;
  logic data_wr, key_wr, data_clr;
  logic launch_ok;

  assign launch_ok = data_full && key_valid;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    blk_d    = blk_q;
    err_d    = err_q;
    in_ready = 1'b0;
    data_clr = 1'b0;

    // Clear first so that a timeout raised below in the same cycle wins.
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if (launch_ok) begin
          // Stall everything in the launch cycle so neither register moves
          // at the edge where AES_en rises.
          state_d = RUN;
          tmo_d   = '0;
          blk_d   = blk_q + CNT_W'(1);
        end else begin
          in_ready = in_is_key ? 1'b1 : !data_full;
        end
      end
      RUN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (AES_data_out_valid) begin
          state_d  = GAP;
          gap_d    = '0;
          data_clr = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // tmo_q counts completed RUN cycles, so this is RUN cycle
          // TIMEOUT_CYCLES; valid in this same cycle took the branch above.
          state_d  = GAP;
          gap_d    = '0;
          data_clr = 1'b1;
          err_d    = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = FILL;
        else                                 gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = FILL;
    endcase
  end

  assign data_wr = in_valid && in_ready && !in_is_key;
  assign key_wr  = in_valid && in_ready &&  in_is_key;

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= FILL;
      tmo_q   <= '0;
      gap_q   <= '0;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

  aes_word_assembler u_data (
    .clk_i   (AES_clk),
    .rst_ni  (AES_rst_n),
    .clr_i   (data_clr),
    .wr_i    (data_wr),
    .word_i  (in_word),
    .block_o (AES_data_in),
    .full_o  (data_full)
  );

  // The key is never cleared by the FSM: it stays valid across blocks until
  // a new key group starts or reset.
  aes_word_assembler u_key (
    .clk_i   (AES_clk),
    .rst_ni  (AES_rst_n),
    .clr_i   (1'b0),
    .wr_i    (key_wr),
    .word_i  (in_word),
    .block_o (AES_key_in),
    .full_o  (key_valid)
  );

  // Decoded straight from the state register so an async reset drops
  // AES_en immediately.
  assign AES_en          = (state_q == RUN);
  assign busy            = (state_q != FILL);
  assign timeout_err     = err_q;
  assign blocks_launched = blk_q;

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for AES_top.
- Accepts a 32-bit word stream with a valid/ready handshake and assembles a 128-bit plaintext block and a 128-bit key.
- Launches one encryption by driving AES_en, AES_data_in and AES_key_in, then holds until AES_top returns AES_data_out_valid.
- Enforces an idle gap between blocks and flags a completion timeout.

Parameters:
- GAP_CYCLES, 4: minimum cycles AES_en stays low between consecutive launches (≥1).
- TIMEOUT_CYCLES, 255: cycles after launch without AES_data_out_valid before abort (≥16).
- CNT_W, 16: width of blocks_launched counter.

Ports:
- AES_clk  in  1  single clock, rising edge.
- AES_rst_n  in  1  reset; asynchronous, active-low.
- in_word  in  32  input word.
- in_valid  in  1  in_word valid.
- in_is_key  in  1  1 = word belongs to key, 0 = word belongs to data block.
- in_ready  out  1  loader accepts word this cycle.
- err_clr  in  1  clears timeout_err.
- AES_data_out_valid  in  1  completion from AES_top.
- AES_en  out  1  enable to AES_top.
- AES_data_in  out  128  plaintext to AES_top.
- AES_key_in  out  128  key to AES_top.
- busy  out  1  block in flight (RUN or GAP).
- timeout_err  out  1  sticky timeout flag.
- blocks_launched  out  CNT_W  count of launches, wraps at 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=FILL, all outputs 0, data/key registers 0, word counters 0, key_valid=0.
- Handshake: transfer occurs when in_valid && in_ready on a rising edge. in_ready is combinational from state and counters only, never from in_valid.
- Word order: the first word of a group is bits [127:96], the fourth is [31:0]. Separate 2-bit counters exist for data and key.
- States:
  - FILL:
    - in_ready=1, except data words are refused (in_ready=0 when in_is_key=0) once 4 data words are held.
    - The 4th key word sets key_valid. A new key group overwrites the previous key word by word; key_valid drops on its first word and is set again on its 4th.
    - When data holds 4 words and key_valid=1, go to RUN on the next edge. AES_en=1 from that edge; blocks_launched increments on the same edge.
  - RUN:
    - in_ready=0. AES_en held 1. AES_data_in and AES_key_in stay stable.
    - Timeout counter increments each cycle.
    - AES_data_out_valid=1: AES_en=0 on the next edge, data counter cleared, go to GAP.
    - Counter reaches TIMEOUT_CYCLES without valid: AES_en=0, timeout_err=1, data counter cleared, go to GAP.
    - Valid and timeout in the same cycle: valid wins, no error.
  - GAP:
    - in_ready=0. AES_en=0. Counts GAP_CYCLES cycles, then returns to FILL.
    - AES_data_out_valid during GAP is ignored.
- AES_data_in/AES_key_in always reflect the assembly registers. They change only in FILL, never while AES_en=1.
- Latency: the 4th qualifying word is accepted at edge N (key already valid), giving AES_en=1 after edge N+1. Minimum launch-to-launch = AES latency + 1 + GAP_CYCLES + 4 fill cycles.
- busy=1 in RUN and GAP.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- Partial data (1–3 words) persists indefinitely in FILL; no flush.
- Reset mid-RUN: AES_en drops immediately (async), in-flight block discarded, key_valid cleared.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLOCK=4.
  - State enum {FILL, RUN, GAP}.
- One natural sub-module: aes_word_assembler. It holds a 4×32 shift-in register with a word counter and full flag, and is instantiated twice (data, key).

Test Plan:
- Reset then key words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc (is_key=1), then data 000000b8, 0, 0, 0 → AES_key_in=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc and AES_data_in=000000b8_00000000_00000000_00000000 when AES_en rises one cycle after the last word; blocks_launched=1; AES_en held until AES_data_out_valid, low the next cycle.
- Data sent before key: data a6f2daeb, 140fa720, 529e75d5, 21cbc681 with no key → AES_en stays 0 and a 5th data word sees in_ready=0. Send the key → launch one cycle after the 4th key word.
- Back-to-back: blocks d7b26248_e8351227_5573a1e5_e8f263b3 and f301a68a_9e9ffa50_844581d9_e290d818 with AES_top model latency 50 → AES_en low for exactly GAP_CYCLES=4 cycles before the 4-word fill; in_ready=0 throughout RUN/GAP.
- Timeout: AES_top model never asserts valid → after 255 cycles AES_en=0 and timeout_err=1. timeout_err persists through the next launch. err_clr pulse → 0.
- Simultaneous: valid in exactly cycle 255 → no error; err_clr coincident with a timeout → timeout_err=1.
- Async reset asserted mid-RUN → AES_en=0 without waiting for a clock edge; after release, no launch until the key is reloaded.
